// File: rtl/jpu_mem_pkg.sv
// rtl/jpu_mem_pkg.sv - shared types and sizing helpers for JPU memory-style buffers
//
// Contents:
//   clog2                   constant function, ceiling log2 of a positive value
//   FIFO_DEFAULT_LENGTH     default FIFO depth
//   FIFO_DEFAULT_PTR_WIDTH  pointer width derived from the default depth
//   fifo_op_t               accepted operation for one FIFO cycle

package jpu_mem_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int FIFO_DEFAULT_LENGTH    = 8;
    localparam int FIFO_DEFAULT_PTR_WIDTH = clog2(FIFO_DEFAULT_LENGTH);

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_t;

endpackage

// File: rtl/fifo_queue_if.sv
// rtl/fifo_queue_if.sv - push/pop handshake and status bundle of fifo_queue
//
// Signals:
//   push      producer requests an enqueue of data_IN
//   pop       consumer requests a dequeue of the head entry
//   data_IN   write data
//   data_OUT  show-ahead head entry, 0 when empty
//   full      occupancy equals length
//   empty     occupancy is zero
//   count     occupancy, 0..length
//   ovf       one-cycle pulse, push rejected while full
//   unf       one-cycle pulse, pop rejected while empty
// Modports:
//   master    the side driving push/pop/data_IN (producer/consumer stage)
//   slave     the FIFO itself

interface fifo_queue_if #(
    parameter int length     = jpu_mem_pkg::FIFO_DEFAULT_LENGTH,
    parameter int data_width = 8
) ();
    import jpu_mem_pkg::*;

    localparam int ptr_width = clog2(length);

    logic                  push;
    logic                  pop;
    logic [data_width-1:0] data_IN;
    logic [data_width-1:0] data_OUT;
    logic                  full;
    logic                  empty;
    logic [ptr_width:0]    count;
    logic                  ovf;
    logic                  unf;

    modport master (
        output push, pop, data_IN,
        input  data_OUT, full, empty, count, ovf, unf
    );

    modport slave (
        input  push, pop, data_IN,
        output data_OUT, full, empty, count, ovf, unf
    );

endinterface

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping pointer counter with increment enable
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low clear to 0
//   inc    advance the pointer by one this cycle
//   value  current pointer, wraps modulo 2**width

module fifo_ptr
    import jpu_mem_pkg::*;
#(
    parameter int width = FIFO_DEFAULT_PTR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [width-1:0] value
);

    // Depth is a power of two, so natural binary overflow is the wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (inc) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_queue.sv
// rtl/fifo_queue.sv - show-ahead first-in/first-out buffer for the JPU datapath
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset; discards all entries
//   bus  fifo_queue_if.slave: push/pop/data_IN in, data_OUT/full/empty/count/ovf/unf out
//
// Parameters:
//   length      number of entries, power of two, at least 2
//   data_width  bits per entry

module fifo_queue
    import jpu_mem_pkg::*;
#(
    parameter int length     = FIFO_DEFAULT_LENGTH,
    parameter int data_width = 8
) (
    input  logic         clk,
    input  logic         rst,
    fifo_queue_if.slave  bus
);

    localparam int ptr_width = clog2(length);
    localparam logic [ptr_width:0] full_count = (ptr_width + 1)'(length);

    logic [data_width-1:0] mem [length];
    logic [ptr_width-1:0]  wr_ptr;
    logic [ptr_width-1:0]  rd_ptr;
    logic [ptr_width:0]    cnt;
    logic                  full_q;
    logic                  empty_q;
    logic                  push_ok;
    logic                  pop_ok;
    logic [length-1:0]     we;
    fifo_op_t              op;

    // Status decodes only from registered occupancy, never from push/pop.
    assign full_q  = (cnt == full_count);
    assign empty_q = (cnt == '0);

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = bus.push && (!full_q || bus.pop);
    assign pop_ok  = bus.pop && !empty_q;

    always_comb begin
        op = OP_NONE;
        unique case ({pop_ok, push_ok})
            2'b01:   op = OP_PUSH;
            2'b10:   op = OP_POP;
            2'b11:   op = OP_BOTH;
            default: op = OP_NONE;
        endcase
    end

    fifo_ptr #(.width(ptr_width)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (push_ok),
        .value (wr_ptr)
    );

    fifo_ptr #(.width(ptr_width)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (pop_ok),
        .value (rd_ptr)
    );

    always_comb begin
        we = '0;
        for (int i = 0; i < length; i++) begin
            we[i] = push_ok && (wr_ptr == ptr_width'(i));
        end
    end

    // Storage is deliberately left out of reset; empty masks stale words.
    for (genvar g = 0; g < length; g++) begin : g_entry
        always_ff @(posedge clk) begin
            if (we[g]) begin
                mem[g] <= bus.data_IN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            case (op)
                OP_PUSH: cnt <= cnt + 1'b1;
                OP_POP:  cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Error pulses: a rejected request this cycle shows for exactly the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ovf <= 1'b0;
            bus.unf <= 1'b0;
        end else begin
            bus.ovf <= bus.push && full_q && !bus.pop;
            bus.unf <= bus.pop && empty_q;
        end
    end

    assign bus.data_OUT = empty_q ? '0 : mem[rd_ptr];
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = cnt;

endmodule
